// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider: FSM states, default
// width and the divide-by-zero result convention.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    // Divide-by-zero: quotient is filled with this bit, remainder returns the dividend.
    localparam logic DBZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor magnitude, keep the difference if non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < dvs, so the shifted value fits WIDTH+1 bits and diff's MSB is the borrow.
    assign shifted  = {rem, dbit};
    assign diff     = shifted - {1'b0, dvs};
    assign qbit     = ~diff[WIDTH];
    assign rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN to honour the sign input (overflow fast path, sign fix-up).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividendIn,
    input  logic [WIDTH-1:0] divisorIn,
    input  logic             sign,
    input  logic             start,
    output logic [WIDTH-1:0] quotientOut,
    output logic [WIDTH-1:0] remainderOut,
    output logic             error,
    output logic             done,
    output logic             busy
);

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] rem_nx;
    logic             qbit;

    logic             sgn, a_neg, b_neg, ovf;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef DIV_SIGNED_EN
    assign sgn = sign;
`else
    logic unused_sign;
    assign unused_sign = sign;
    assign sgn         = 1'b0;
`endif

    assign a_neg = sgn & dividendIn[WIDTH-1];
    assign b_neg = sgn & divisorIn[WIDTH-1];
    assign a_mag = a_neg ? -dividendIn : dividendIn;
    assign b_mag = b_neg ? -divisorIn  : divisorIn;
    assign ovf   = sgn && (dividendIn == MOST_NEG) && (&divisorIn);

    // quo_r starts as the dividend magnitude and is shifted out MSB-first while
    // quotient bits shift in at the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .dbit     (quo_r[WIDTH-1]),
        .dvs      (dvs_r),
        .rem_next (rem_nx),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rem_r        <= '0;
            quo_r        <= '0;
            dvs_r        <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            quotientOut  <= '0;
            remainderOut <= '0;
            error        <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (divisorIn == '0) begin
                        quotientOut  <= {WIDTH{DBZ_QUOT_BIT}};
                        remainderOut <= dividendIn;
                        error        <= 1'b1;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else if (ovf) begin
                        quotientOut  <= MOST_NEG;
                        remainderOut <= '0;
                        error        <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        rem_r <= '0;
                        quo_r <= a_mag;
                        dvs_r <= b_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem_r <= rem_nx;
                    quo_r <= {quo_r[WIDTH-2:0], qbit};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    quotientOut  <= neg_q ? -quo_r : quo_r;
                    remainderOut <= neg_r ? -rem_r : rem_r;
                    error        <= 1'b0;
                    done         <= 1'b1;
                    cnt          <= '0;
                    state        <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: WIDTH=32 instance for most scenarios plus a
// WIDTH=8 instance; signed expectations follow the DIV_SIGNED_EN build option.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dividendIn = '0, divisorIn = '0;
    logic        sign = 1'b0, start = 1'b0;
    logic [31:0] quotientOut, remainderOut;
    logic        error, done, busy;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        s8 = 1'b0, st8 = 1'b0;
    logic [7:0]  q8, r8;
    logic        e8, d8, bz8;

    int checks = 0;
    int errors = 0;

`ifdef DIV_SIGNED_EN
    localparam logic [31:0] EXP_NEG_Q = 32'hFFFFFFF2, EXP_NEG_R = 32'hFFFFFFFE;
    localparam logic [31:0] EXP_M2_Q  = 32'hFFFFFFFD, EXP_M2_R  = 32'h00000001;
    localparam logic [31:0] EXP_OVF_Q = 32'h80000000, EXP_OVF_R = 32'h00000000;
    localparam int          EXP_OVF_OFF = 0;
`else
    // Unsigned build: 0xFFFFFF9C/7 = 0x24924916 r 2, 7/0xFFFFFFFE = 0 r 7.
    localparam logic [31:0] EXP_NEG_Q = 32'h24924916, EXP_NEG_R = 32'h00000002;
    localparam logic [31:0] EXP_M2_Q  = 32'h00000000, EXP_M2_R  = 32'h00000007;
    localparam logic [31:0] EXP_OVF_Q = 32'h00000000, EXP_OVF_R = 32'h80000000;
    localparam int          EXP_OVF_OFF = 33;
`endif

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .dividendIn(dividendIn), .divisorIn(divisorIn),
        .sign(sign), .start(start), .quotientOut(quotientOut),
        .remainderOut(remainderOut), .error(error), .done(done), .busy(busy)
    );

    seq_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .dividendIn(a8), .divisorIn(b8),
        .sign(s8), .start(st8), .quotientOut(q8),
        .remainderOut(r8), .error(e8), .done(d8), .busy(bz8)
    );

    // Issues one request, scrambles operands after acceptance, and reports the
    // result, the edge offset of done from the accepting edge, busy cycle count,
    // and done/busy one cycle after the pulse.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r, output logic e,
                          output int off, output int bcnt, output logic post_done,
                          output logic post_busy);
        int n;
        @(negedge clk);
        dividendIn = a; divisorIn = b; sign = s; start = 1'b1;
        off = -1; bcnt = 0; n = 0;
        while (n < 200 && off < 0) begin
            @(posedge clk); #1;
            if (n == 0) begin
                start = 1'b0; dividendIn = $urandom; divisorIn = $urandom; sign = ~s;
            end
            if (busy) bcnt++;
            if (done) off = n;
            n++;
        end
        q = quotientOut; r = remainderOut; e = error;
        @(posedge clk); #1;
        post_done = done; post_busy = busy;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (quotientOut !== 32'h0 || remainderOut !== 32'h0) begin errors++;
            $display("FAIL reset_outputs: got q=%h r=%h want 0/0", quotientOut, remainderOut); end
        checks++; if ({error, done, busy} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got err/done/busy=%b want 000", {error, done, busy}); end
        checks++; if ({q8, r8, e8, d8, bz8} !== 19'h0) begin errors++;
            $display("FAIL reset_w8: got q=%h r=%h flags=%b want zeros", q8, r8, {e8, d8, bz8}); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [31:0] q, r; logic e, pd, pb; int off, bc;
        run_op(32'd100, 32'd7, 1'b0, q, r, e, off, bc, pd, pb);
        checks++; if (q !== 32'd14 || r !== 32'd2 || e !== 1'b0) begin errors++;
            $display("FAIL udiv_100_7: got q=%0d r=%0d e=%b want 14 2 0", q, r, e); end
        checks++; if (off !== 33) begin errors++;
            $display("FAIL udiv_latency: got done offset %0d want 33", off); end
        checks++; if (bc !== 34) begin errors++;
            $display("FAIL udiv_busy_cycles: got %0d want 34", bc); end
        checks++; if (pd !== 1'b0 || pb !== 1'b0) begin errors++;
            $display("FAIL udiv_pulse: got done=%b busy=%b after pulse want 0 0", pd, pb); end
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, q, r, e, off, bc, pd, pb);
        checks++; if (q !== 32'hFFFFFFFF || r !== 32'h0 || e !== 1'b0) begin errors++;
            $display("FAIL udiv_max_by_1: got q=%h r=%h e=%b want ffffffff 0 0", q, r, e); end
    endtask

    task automatic test_signed();
        logic [31:0] q, r; logic e, pd, pb; int off, bc;
        run_op(32'hFFFFFF9C, 32'd7, 1'b1, q, r, e, off, bc, pd, pb);
        checks++; if (q !== EXP_NEG_Q || r !== EXP_NEG_R) begin errors++;
            $display("FAIL sdiv_m100_7: got q=%h r=%h want %h %h", q, r, EXP_NEG_Q, EXP_NEG_R); end
        checks++; if (off !== 33) begin errors++;
            $display("FAIL sdiv_latency: got done offset %0d want 33", off); end
        run_op(32'hFFFFFF9C, 32'd7, 1'b0, q, r, e, off, bc, pd, pb);
        checks++; if (q !== 32'h24924916 || r !== 32'h2) begin errors++;
            $display("FAIL udiv_m100_7: got q=%h r=%h want 24924916 2", q, r); end
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, q, r, e, off, bc, pd, pb);
        checks++; if (q !== EXP_M2_Q || r !== EXP_M2_R) begin errors++;
            $display("FAIL sdiv_7_m2: got q=%h r=%h want %h %h", q, r, EXP_M2_Q, EXP_M2_R); end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; logic e, pd, pb; int off, bc;
        run_op(32'h00001234, 32'h0, 1'b0, q, r, e, off, bc, pd, pb);
        checks++; if (q !== 32'hFFFFFFFF || r !== 32'h00001234 || e !== 1'b1) begin errors++;
            $display("FAIL dbz_result: got q=%h r=%h e=%b want ffffffff 1234 1", q, r, e); end
        checks++; if (off !== 0 || bc !== 1) begin errors++;
            $display("FAIL dbz_timing: got offset %0d busy %0d want 0 1", off, bc); end
        checks++; if (pd !== 1'b0 || pb !== 1'b0) begin errors++;
            $display("FAIL dbz_pulse: got done=%b busy=%b after pulse want 0 0", pd, pb); end
        run_op(32'hFFFFFFFB, 32'h0, 1'b1, q, r, e, off, bc, pd, pb);
        checks++; if (q !== 32'hFFFFFFFF || r !== 32'hFFFFFFFB || e !== 1'b1) begin errors++;
            $display("FAIL dbz_signed: got q=%h r=%h e=%b want ffffffff fffffffb 1", q, r, e); end
        run_op(32'd9, 32'd2, 1'b0, q, r, e, off, bc, pd, pb);
        checks++; if (q !== 32'd4 || r !== 32'd1 || e !== 1'b0) begin errors++;
            $display("FAIL error_clear: got q=%0d r=%0d e=%b want 4 1 0", q, r, e); end
    endtask

    task automatic test_overflow();
        logic [31:0] q, r; logic e, pd, pb; int off, bc;
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, q, r, e, off, bc, pd, pb);
        checks++; if (q !== EXP_OVF_Q || r !== EXP_OVF_R || e !== 1'b0) begin errors++;
            $display("FAIL ovf_result: got q=%h r=%h e=%b want %h %h 0", q, r, e, EXP_OVF_Q, EXP_OVF_R); end
        checks++; if (off !== EXP_OVF_OFF) begin errors++;
            $display("FAIL ovf_latency: got offset %0d want %0d", off, EXP_OVF_OFF); end
    endtask

    // Start held through the DONE cycle is dropped; the next IDLE cycle accepts it.
    task automatic test_back_to_back();
        @(negedge clk);
        dividendIn = 32'h1234; divisorIn = 32'h0; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++;
            $display("FAIL b2b_first_done: got %b want 1", done); end
        dividendIn = 32'd50;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || remainderOut !== 32'h1234) begin errors++;
            $display("FAIL b2b_ignored: got done=%b busy=%b r=%h want 0 0 1234", done, busy, remainderOut); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (done !== 1'b1 || remainderOut !== 32'd50) begin errors++;
            $display("FAIL b2b_second: got done=%b r=%0d want 1 50", done, remainderOut); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [31:0] q, r; logic e, pd, pb; int off, bc;
        logic seen_done, busy_mid;
        seen_done = 1'b0; busy_mid = 1'b0;
        @(negedge clk);
        dividendIn = 32'd42; divisorIn = 32'd5; sign = 1'b0; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
            if (c == 0) start = 1'b0;
            if (c == 4) begin dividendIn = 32'd9; divisorIn = 32'd3; start = 1'b1; end
            if (c == 5) start = 1'b0;
            if (c == 8) busy_mid = busy;
            if (c == 9) reset = 1'b0;
        end
        checks++; if (busy_mid !== 1'b1) begin errors++;
            $display("FAIL abort_busy_before: got %b want 1", busy_mid); end
        checks++; if (quotientOut !== 32'h0 || remainderOut !== 32'h0 || busy !== 1'b0 || error !== 1'b0) begin errors++;
            $display("FAIL abort_state: got q=%h r=%h busy=%b err=%b want 0 0 0 0", quotientOut, remainderOut, busy, error); end
        checks++; if (seen_done !== 1'b0) begin errors++;
            $display("FAIL abort_no_done: got %b want 0", seen_done); end
        @(negedge clk); reset = 1'b1;
        run_op(32'd9, 32'd3, 1'b0, q, r, e, off, bc, pd, pb);
        checks++; if (q !== 32'd3 || r !== 32'd0 || off !== 33) begin errors++;
            $display("FAIL abort_restart: got q=%0d r=%0d off=%0d want 3 0 33", q, r, off); end
    endtask

    task automatic test_width8();
        int off;
        off = -1;
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd3; s8 = 1'b0; st8 = 1'b1;
        for (int n = 0; n < 40 && off < 0; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin st8 = 1'b0; a8 = 8'hA5; b8 = 8'h00; end
            if (d8) off = n;
        end
        checks++; if (q8 !== 8'd66 || r8 !== 8'd2 || e8 !== 1'b0) begin errors++;
            $display("FAIL w8_200_3: got q=%0d r=%0d e=%b want 66 2 0", q8, r8, e8); end
        checks++; if (off !== 9) begin errors++;
            $display("FAIL w8_latency: got done offset %0d want 9", off); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
